// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - EX-stage ALU: field decode, execute, registered result with valid/ready handshake
// Define ALU_EXEC_MULDIV_EN to add iterative RV32M multiply/divide (WIDTH+1 cycle latency).
module alu_exec_unit #(
    parameter int WIDTH = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALU_Op,
    input  logic [2:0]       Funct3,
    input  logic             Funct7,
    input  logic             Funct7_0,
    input  logic             op5,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_Result,
    output logic [3:0]       ALU_Control,
    output logic             Zero
);
    localparam logic [1:0] IDLE = 2'd0;
`ifdef ALU_EXEC_MULDIV_EN
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
`endif

    localparam logic [3:0] C_ADD  = 4'b0000;
    localparam logic [3:0] C_SUB  = 4'b0001;
    localparam logic [3:0] C_SLL  = 4'b0010;
    localparam logic [3:0] C_SLT  = 4'b0011;
    localparam logic [3:0] C_SLTU = 4'b0100;
    localparam logic [3:0] C_XOR  = 4'b0101;
    localparam logic [3:0] C_SRL  = 4'b0110;
    localparam logic [3:0] C_SRA  = 4'b0111;
    localparam logic [3:0] C_OR   = 4'b1000;
    localparam logic [3:0] C_AND  = 4'b1001;

    logic [1:0]         state;
    logic [3:0]         ctrl;
    logic               is_m;
    logic [WIDTH-1:0]   alu_res;
    logic               accept;
    logic               consume;
    logic [SHAMT_W-1:0] shamt;

    assign in_ready = (state == IDLE) & (!out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    assign consume  = out_valid & out_ready;
    assign shamt    = SrcB[SHAMT_W-1:0];
    assign Zero     = (ALU_Result == '0);

    always_comb begin
        ctrl = C_ADD;
        is_m = 1'b0;
        if (ALU_Op == 2'b01) begin
            ctrl = C_SUB;
        end else if (ALU_Op == 2'b10) begin
            case (Funct3)
                3'b000:  ctrl = (op5 & Funct7) ? C_SUB : C_ADD;
                3'b001:  ctrl = C_SLL;
                3'b010:  ctrl = C_SLT;
                3'b011:  ctrl = C_SLTU;
                3'b100:  ctrl = C_XOR;
                3'b101:  ctrl = Funct7 ? C_SRA : C_SRL;
                3'b110:  ctrl = C_OR;
                default: ctrl = C_AND;
            endcase
`ifdef ALU_EXEC_MULDIV_EN
            // REM/REMU report the DIV/DIVU codes; the stored funct3 selects the remainder
            if (op5 & Funct7_0) begin
                is_m = 1'b1;
                case (Funct3)
                    3'b000:  ctrl = 4'b1010;
                    3'b001:  ctrl = 4'b1011;
                    3'b010:  ctrl = 4'b1100;
                    3'b011:  ctrl = 4'b1101;
                    3'b100:  ctrl = 4'b1110;
                    3'b101:  ctrl = 4'b1111;
                    3'b110:  ctrl = 4'b1110;
                    default: ctrl = 4'b1111;
                endcase
            end
`endif
        end
    end

    always_comb begin
        alu_res = '0;
        case (ctrl)
            C_ADD:   alu_res = SrcA + SrcB;
            C_SUB:   alu_res = SrcA - SrcB;
            C_SLL:   alu_res = SrcA << shamt;
            C_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            C_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
            C_XOR:   alu_res = SrcA ^ SrcB;
            C_SRL:   alu_res = SrcA >> shamt;
            C_SRA:   alu_res = $signed(SrcA) >>> shamt;
            C_OR:    alu_res = SrcA | SrcB;
            C_AND:   alu_res = SrcA & SrcB;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_MULDIV_EN
    logic [SHAMT_W-1:0]   cnt;
    logic [WIDTH-1:0]     hi, lo, mreg, saved_a, hi_nxt, lo_nxt, mag_a, mag_b, m_res, q, r;
    logic [2:0]           m_f3;
    logic [3:0]           m_ctrl;
    logic                 neg_a, neg_b, div0, sa, sb;
    logic [WIDTH:0]       sum, rs, diff;
    logic [2*WIDTH-1:0]   prod;

    assign sa    = (Funct3 == 3'b001 || Funct3 == 3'b010 || Funct3 == 3'b100 || Funct3 == 3'b110) & SrcA[WIDTH-1];
    assign sb    = (Funct3 == 3'b001 || Funct3 == 3'b100 || Funct3 == 3'b110) & SrcB[WIDTH-1];
    assign mag_a = sa ? -SrcA : SrcA;
    assign mag_b = sb ? -SrcB : SrcB;

    // One shift-add (multiply) or restoring-subtract (divide) step on {hi, lo}
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, mreg} : '0);
        rs   = {hi, lo[WIDTH-1]};
        diff = rs - {1'b0, mreg};
        if (m_f3[2]) begin
            hi_nxt = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], !diff[WIDTH]};
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

    always_comb begin
        prod = (neg_a ^ neg_b) ? -{hi, lo} : {hi, lo};
        q    = div0 ? '1 : ((neg_a ^ neg_b) ? -lo : lo);
        r    = div0 ? saved_a : (neg_a ? -hi : hi);
        case (m_f3)
            3'b000:         m_res = prod[WIDTH-1:0];
            3'b100, 3'b101: m_res = q;
            3'b110, 3'b111: m_res = r;
            default:        m_res = prod[2*WIDTH-1:WIDTH];
        endcase
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && accept && is_m) begin
            hi      <= '0;
            lo      <= Funct3[2] ? mag_a : mag_b;
            mreg    <= Funct3[2] ? mag_b : mag_a;
            m_f3    <= Funct3;
            m_ctrl  <= ctrl;
            neg_a   <= sa;
            neg_b   <= sb;
            div0    <= (SrcB == '0);
            saved_a <= SrcA;
        end else if (state == ITER) begin
            hi <= hi_nxt;
            lo <= lo_nxt;
        end
    end
`else
    logic unused_funct7_0;
    assign unused_funct7_0 = Funct7_0 | is_m;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            out_valid   <= 1'b0;
            ALU_Result  <= '0;
            ALU_Control <= 4'b0000;
`ifdef ALU_EXEC_MULDIV_EN
            cnt         <= '0;
`endif
        end else begin
            if (consume) out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !is_m) begin
                        ALU_Result  <= alu_res;
                        ALU_Control <= ctrl;
                        out_valid   <= 1'b1;
                    end
`ifdef ALU_EXEC_MULDIV_EN
                    else if (accept) begin
                        state <= ITER;
                        cnt   <= '0;
                    end
`endif
                end
`ifdef ALU_EXEC_MULDIV_EN
                ITER: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == SHAMT_W'(WIDTH-1)) state <= DONE;
                end
                DONE: begin
                    ALU_Result  <= m_res;
                    ALU_Control <= m_ctrl;
                    out_valid   <= 1'b1;
                    state       <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed-vector bench for alu_exec_unit
// M-extension vectors run only when ALU_EXEC_MULDIV_EN is defined.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  ALU_Op;
    logic [2:0]  Funct3;
    logic        Funct7;
    logic        Funct7_0;
    logic        op5;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALU_Result;
    logic [3:0]  ALU_Control;
    logic        Zero;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALU_Op(ALU_Op), .Funct3(Funct3), .Funct7(Funct7), .Funct7_0(Funct7_0), .op5(op5),
        .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid), .out_ready(out_ready),
        .ALU_Result(ALU_Result), .ALU_Control(ALU_Control), .Zero(Zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Presents one operation and returns #1 after the edge on which it was accepted
    task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f7, input logic f70,
                        input logic o5, input logic [31:0] a, input logic [31:0] b);
        int guard = 0;
        ALU_Op = op; Funct3 = f3; Funct7 = f7; Funct7_0 = f70; op5 = o5; SrcA = a; SrcB = b;
        in_valid = 1'b1;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("send_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic alu1(input string tag, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic f70, input logic o5, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic [3:0] exp_ctrl);
        send(op, f3, f7, f70, o5, a, b);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_res"}, ALU_Result, exp_res);
        chk({tag, "_ctrl"}, {28'd0, ALU_Control}, {28'd0, exp_ctrl});
        chk({tag, "_zero"}, {31'd0, Zero}, {31'd0, (exp_res == 32'd0)});
    endtask

`ifdef ALU_EXEC_MULDIV_EN
    task automatic mop(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic [3:0] exp_ctrl);
        int lat = 0;
        send(2'b10, f3, 1'b0, 1'b1, 1'b1, a, b);
        chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 32'd33);
        chk({tag, "_res"}, ALU_Result, exp_res);
        chk({tag, "_ctrl"}, {28'd0, ALU_Control}, {28'd0, exp_ctrl});
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALU_Op = 2'b00; Funct3 = 3'b000; Funct7 = 1'b0; Funct7_0 = 1'b0; op5 = 1'b0;
        SrcA = 32'd0; SrcB = 32'd0;
        #2;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_res", ALU_Result, 32'd0);
        chk("rst_ctrl", {28'd0, ALU_Control}, 32'd0);
        chk("rst_zero", {31'd0, Zero}, 32'd1);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        alu1("sub",   2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 32'd5, 32'd7, 32'hFFFF_FFFE, 4'b0001);
        alu1("addi",  2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 4'b0000);
        alu1("sra",   2'b10, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h24, 32'hF800_0000, 4'b0111);
        alu1("srl",   2'b10, 3'b101, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h24, 32'h0800_0000, 4'b0110);
        alu1("cmp",   2'b01, 3'b000, 1'b0, 1'b0, 1'b1, 32'd9, 32'd9, 32'd0, 4'b0001);
        alu1("slt",   2'b10, 3'b010, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd1, 4'b0011);
        alu1("sltu",  2'b10, 3'b011, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0100);
        alu1("sll",   2'b10, 3'b001, 1'b0, 1'b0, 1'b1, 32'd1, 32'd33, 32'd2, 4'b0010);
        alu1("xor",   2'b10, 3'b100, 1'b0, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'h0FF0, 4'b0101);
        alu1("or",    2'b10, 3'b110, 1'b0, 1'b0, 1'b1, 32'hF0F0, 32'h0F00, 32'hFFF0, 4'b1000);
        alu1("and",   2'b10, 3'b111, 1'b0, 1'b0, 1'b1, 32'hF0F0, 32'hFF00, 32'hF000, 4'b1001);
        alu1("rsvd",  2'b11, 3'b111, 1'b1, 1'b0, 1'b1, 32'd3, 32'd4, 32'd7, 4'b0000);
        alu1("wrap",  2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 4'b0000);
`ifndef ALU_EXEC_MULDIV_EN
        alu1("f70ign", 2'b10, 3'b000, 1'b0, 1'b1, 1'b1, 32'd6, 32'd7, 32'd13, 4'b0000);
`endif

        // Backpressure: first result held while two more ADDs wait
        @(posedge clk); #1;
        out_ready = 1'b0;
        ALU_Op = 2'b00; Funct3 = 3'b000; Funct7 = 1'b0; Funct7_0 = 1'b0; op5 = 1'b1;
        SrcA = 32'd1; SrcB = 32'd1; in_valid = 1'b1;
        @(posedge clk); #1;
        SrcA = 32'd2; SrcB = 32'd2;
        for (int i = 0; i < 4; i++) begin
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold_res", ALU_Result, 32'd2);
            chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_second", ALU_Result, 32'd4);
        chk("bp_second_valid", {31'd0, out_valid}, 32'd1);
        SrcA = 32'd3; SrcB = 32'd3;
        @(posedge clk); #1;
        chk("bp_third", ALU_Result, 32'd6);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

`ifdef ALU_EXEC_MULDIV_EN
        mop("mul",    3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 4'b1010);
        mop("mulh",   3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 4'b1011);
        mop("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b1101);
        mop("div_ov", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b1110);
        mop("rem_ov", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 4'b1110);
        mop("divu0",  3'b101, 32'd10, 32'd0, 32'hFFFF_FFFF, 4'b1111);
        mop("remu0",  3'b111, 32'd10, 32'd0, 32'd10, 4'b1111);
        mop("div_n",  3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 4'b1110);
        mop("rem_n",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 4'b1110);

        // Reset in the middle of an iteration discards the operation
        @(posedge clk); #1;
        send(2'b10, 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7);
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        chk("rstiter_valid", {31'd0, out_valid}, 32'd0);
        chk("rstiter_res", ALU_Result, 32'd0);
        chk("rstiter_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        alu1("post_rst", 2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2, 32'd3, 4'b0000);
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("post_rst_idle", {31'd0, out_valid}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
